decoder2to4_timed: RTL

- Registered 2-to-4 decoder with a valid/ready input handshake. It is the receive-side counterpart of the 4-to-2 encoder.
- Takes a 2-bit code and drives the matching one-hot line for exactly HOLD_CYCLES clocks.
- After each pulse it enforces an all-zero gap of GAP_CYCLES before accepting the next code (break-before-make).
- Sits between the encoder/command source and the downstream select lines.

---
 rtl/decoder2to4_timed_if.sv | 35 +++
 rtl/decoder2to4_timed.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/decoder2to4_timed_if.sv
// Handshake and select-line bundle for decoder2to4_timed.
// Parity signals exist only when DECODER2TO4_PARITY_EN is defined.
interface decoder2to4_timed_if;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] code;
  logic [3:0] d;
  logic       d_valid;
  logic       busy;
`ifdef DECODER2TO4_PARITY_EN
  logic       code_par;
  logic       par_err;

  modport master (
    output en, in_valid, code, code_par,
    input  in_ready, d, d_valid, busy, par_err
  );

  modport slave (
    input  en, in_valid, code, code_par,
    output in_ready, d, d_valid, busy, par_err
  );
`else
  modport master (
    output en, in_valid, code,
    input  in_ready, d, d_valid, busy
  );

  modport slave (
    input  en, in_valid, code,
    output in_ready, d, d_valid, busy
  );
`endif
endinterface

// File: rtl/decoder2to4_timed.sv
// Registered 2-to-4 decoder: accepts a code over valid/ready, drives one-hot d for HOLD_CYCLES
// clocks, then an all-zero gap of GAP_CYCLES. Optional parity check: DECODER2TO4_PARITY_EN.
module decoder2to4_timed #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input logic                clk,
  input logic                rst_n,
  decoder2to4_timed_if.slave dec_io
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StGap  = 2'd2
  } state_e;

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit         HasGap   = (GAP_CYCLES > 0);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] d_q, d_d;
  logic       d_valid_q, d_valid_d;
  logic       busy_q, busy_d;
  logic       in_ready;
  logic       xfer;
  logic       code_ok;

`ifdef DECODER2TO4_PARITY_EN
  logic par_err_q, par_err_d;

  // Even parity over {code, code_par}: odd count of ones marks a corrupted code.
  assign code_ok = ~(^{dec_io.code, dec_io.code_par});
`else
  assign code_ok = 1'b1;
`endif

  // Gated by rst_n so the source never sees ready while the block is held in reset.
  assign in_ready = rst_n && (state_q == StIdle) && dec_io.en;
  assign xfer     = dec_io.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    d_valid_d = d_valid_q;
    busy_d    = busy_q;
`ifdef DECODER2TO4_PARITY_EN
    par_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (xfer && code_ok) begin
          d_d       = 4'b0001 << dec_io.code;
          d_valid_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = HoldLoad;
          state_d   = StHold;
        end
`ifdef DECODER2TO4_PARITY_EN
        // A bad code is consumed but yields no pulse.
        par_err_d = xfer && !code_ok;
`endif
      end

      StHold: begin
        if (!dec_io.en || (cnt_q == 8'd0)) begin
          d_d       = 4'b0000;
          d_valid_d = 1'b0;
          if (HasGap) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end else begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StGap: begin
        // en is deliberately ignored here: the gap is never shortened.
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d   = StIdle;
        cnt_d     = 8'd0;
        d_d       = 4'b0000;
        d_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      d_q       <= 4'b0000;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      busy_q    <= busy_d;
    end
  end

`ifdef DECODER2TO4_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign dec_io.par_err = par_err_q;
`endif

  assign dec_io.in_ready = in_ready;
  assign dec_io.d        = d_q;
  assign dec_io.d_valid  = d_valid_q;
  assign dec_io.busy     = busy_q;

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(d_q));
  a_dvalid  : assert property (@(posedge clk) disable iff (!rst_n) d_valid_q == (d_q != 4'd0));
  a_idle_nb : assert property (@(posedge clk) disable iff (!rst_n)
                               (state_q == StIdle) |-> !busy_q);

endmodule
